// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: FSM states and framing constants.
package inst_loader_pkg;

    // Bytes that make up one instruction word or the header word count.
    localparam int BYTES_PER_WORD = 4;

    // Length of the program-length header, in bytes.
    localparam int HDR_BYTES = 4;

    // Width of the per-word byte counter inside the packer.
    localparam int BYTE_CNT_W = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } ld_state_t;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Little-endian byte-to-word assembler. The first byte of a group lands in
// bits 7:0. word_done pulses combinationally on the last byte of a group, and
// word presents the completed value in that same cycle so the caller can act
// on it without an extra cycle of latency.
module byte_packer
    import inst_loader_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [7:0]   din,
    output logic [W-1:0] word,
    output logic         word_done
);

    localparam int AW = BYTES_PER_WORD * 8;

    logic [AW-1:0]         shreg;
    logic [AW-1:0]         shreg_next;
    logic [BYTE_CNT_W-1:0] byte_cnt;

    // New byte enters at the top so that after a full group the first byte
    // has been shifted down into the least significant position.
    assign shreg_next = {din, shreg[AW-1:8]};
    assign word_done  = en && (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    assign word       = W'(shreg_next);

    // Shift register and byte counter; the counter wraps after each group.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (en) begin
            shreg    <= shreg_next;
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Serial program loader: receives a 4-byte little-endian word count followed
// by that many little-endian instruction words, writes each word into the
// instruction RAM at consecutive byte addresses, and releases the core from
// reset once the whole program has been written.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int W         = 32,
    parameter int MAX_WORDS = 2048
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic         is_write,
    output logic [W-1:0] im_addr,
    output logic [W-1:0] im_inst,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         core_rst
);

    // Wide enough to hold MAX_WORDS itself, since N may equal it.
    localparam int IW = $clog2(MAX_WORDS + 1);

    ld_state_t      state;
    logic [IW-1:0]  word_idx;
    logic [IW-1:0]  n_words;
    logic [IW-1:0]  idx_inc;
    logic [W-1:0]   idx_ext;
    logic           pk_en;
    logic           pk_clr;
    logic           pk_done;
    logic [W-1:0]   pk_word;
    logic           hdr_bad;
    logic           can_start;

    assign can_start = (state == IDLE) || (state == DONE) || (state == ERR);
    assign pk_en     = rx_valid && rx_ready;
    assign pk_clr    = start && can_start;
    assign idx_inc   = word_idx + 1'b1;
    assign idx_ext   = W'(word_idx);
    // The range check uses the full header value before it is narrowed to IW.
    assign hdr_bad   = (pk_word == '0) || (pk_word > W'(MAX_WORDS));

    byte_packer #(
        .W (W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pk_clr),
        .en        (pk_en),
        .din       (rx_data),
        .word      (pk_word),
        .word_done (pk_done)
    );

    // Load sequencer; every output is registered and updated together with
    // the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            word_idx <= '0;
            n_words  <= '0;
            rx_ready <= 1'b0;
            is_write <= 1'b0;
            im_addr  <= '0;
            im_inst  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            core_rst <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= HDR;
                        word_idx <= '0;
                        rx_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        core_rst <= 1'b1;
                    end
                end
                HDR: begin
                    if (pk_done) begin
                        n_words <= IW'(pk_word);
                        if (hdr_bad) begin
                            state    <= ERR;
                            rx_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (pk_done) begin
                        state    <= WRITE;
                        rx_ready <= 1'b0;
                        is_write <= 1'b1;
                        im_inst  <= pk_word;
                        im_addr  <= idx_ext << 2;
                    end
                end
                WRITE: begin
                    is_write <= 1'b0;
                    word_idx <= idx_inc;
                    if (idx_inc == n_words) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        core_rst <= 1'b0;
                    end else begin
                        state    <= DATA;
                        rx_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    rx_ready <= 1'b0;
                    is_write <= 1'b0;
                    busy     <= 1'b0;
                    core_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: expected RAM writes are queued as the
// stream is driven and matched against every is_write pulse.
module tb_inst_loader;

    localparam int W         = 32;
    localparam int MAX_WORDS = 2048;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic         is_write;
    logic [W-1:0] im_addr;
    logic [W-1:0] im_inst;
    logic         busy;
    logic         done;
    logic         err;
    logic         core_rst;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0]  exp_q[$];
    logic [31:0]  tx_words[8];

    inst_loader #(
        .W         (W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .is_write (is_write),
        .im_addr  (im_addr),
        .im_inst  (im_inst),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .core_rst (core_rst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (is_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {im_addr, im_inst}, 64'h0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("write_addr", 64'(im_addr), 64'(e[63:32]));
                chk("write_inst", 64'(im_inst), 64'(e[31:0]));
                chk("rx_ready_in_write", 64'(rx_ready), 64'h0);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'h0);
        chk({tag, "_is_write"}, 64'(is_write), 64'h0);
        chk({tag, "_im_addr"},  64'(im_addr),  64'h0);
        chk({tag, "_im_inst"},  64'(im_inst),  64'h0);
        chk({tag, "_busy"},     64'(busy),     64'h0);
        chk({tag, "_done"},     64'(done),     64'h0);
        chk({tag, "_err"},      64'(err),      64'h0);
        chk({tag, "_core_rst"}, 64'(core_rst), 64'h1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte and hold it until the loader takes it (bounded).
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int guard;
        if (rnd) begin
            while ($urandom_range(0, 1) == 1) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        while (rx_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("byte_accept_timeout", 64'h0, 64'h1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], rnd);
    endtask

    task automatic wait_end(input string tag);
        int guard = 0;
        while (done !== 1'b1 && err !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk({tag, "_timeout"}, 64'h0, 64'h1);
    endtask

    // Full load of nw words from tx_words with header value n.
    task automatic load(input logic [31:0] n, input int nw, input bit rnd);
        pulse_start();
        send_word(n, rnd);
        for (int i = 0; i < nw; i++) begin
            exp_q.push_back({32'(i * 4), tx_words[i]});
            send_word(tx_words[i], rnd);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        @(negedge clk);
        do_reset();
        check_reset_outputs("reset");

        // Single-word program.
        tx_words[0] = 32'h0000_0013;
        load(32'd1, 1, 1'b0);
        wait_end("n1");
        @(negedge clk);
        chk("n1_done", 64'(done), 64'h1);
        chk("n1_core_rst", 64'(core_rst), 64'h0);
        chk("n1_busy", 64'(busy), 64'h0);
        chk("n1_rx_ready", 64'(rx_ready), 64'h0);
        chk("n1_pending", 64'(exp_q.size()), 64'h0);

        // Trailing bytes after DONE are not consumed and cause no writes.
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        chk("post_done_still_done", 64'(done), 64'h1);

        // Three words at consecutive addresses.
        tx_words[0] = 32'hAABB_CCDD;
        tx_words[1] = 32'h1122_3344;
        tx_words[2] = 32'hDEAD_BEEF;
        load(32'd3, 3, 1'b0);
        wait_end("n3");
        chk("n3_done", 64'(done), 64'h1);
        chk("n3_err", 64'(err), 64'h0);
        chk("n3_pending", 64'(exp_q.size()), 64'h0);

        // N == 0 is rejected.
        load(32'd0, 0, 1'b0);
        wait_end("n0");
        @(negedge clk);
        chk("n0_err", 64'(err), 64'h1);
        chk("n0_done", 64'(done), 64'h0);
        chk("n0_core_rst", 64'(core_rst), 64'h1);
        chk("n0_busy", 64'(busy), 64'h0);

        // N == MAX_WORDS + 1 is rejected.
        load(32'(MAX_WORDS + 1), 0, 1'b0);
        wait_end("nmax1");
        chk("nmax1_err", 64'(err), 64'h1);
        chk("nmax1_core_rst", 64'(core_rst), 64'h1);

        // N == MAX_WORDS is accepted: loader sits in DATA waiting for bytes.
        load(32'(MAX_WORDS), 0, 1'b0);
        repeat (2) @(negedge clk);
        chk("nmax_err", 64'(err), 64'h0);
        chk("nmax_busy", 64'(busy), 64'h1);
        chk("nmax_rx_ready", 64'(rx_ready), 64'h1);
        do_reset();

        // Throttled byte stream yields the same writes.
        tx_words[0] = 32'h0102_0304;
        tx_words[1] = 32'hF0E1_D2C3;
        load(32'd2, 2, 1'b1);
        wait_end("rnd");
        chk("rnd_done", 64'(done), 64'h1);
        chk("rnd_pending", 64'(exp_q.size()), 64'h0);

        // Abort after six data bytes; the first word has already been written.
        pulse_start();
        send_word(32'd3, 1'b0);
        exp_q.push_back({32'h0, 32'hCAFE_F00D});
        send_word(32'hCAFE_F00D, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h66, 1'b0);
        do_reset();
        check_reset_outputs("abort");
        chk("abort_pending", 64'(exp_q.size()), 64'h0);

        tx_words[0] = 32'h8765_4321;
        load(32'd1, 1, 1'b0);
        wait_end("after_abort");
        chk("after_abort_done", 64'(done), 64'h1);
        chk("after_abort_core_rst", 64'(core_rst), 64'h0);

        // start during a load is ignored.
        tx_words[0] = 32'h1357_9BDF;
        tx_words[1] = 32'h2468_ACE0;
        pulse_start();
        send_word(32'd2, 1'b0);
        send_byte(tx_words[0][7:0], 1'b0);
        pulse_start();
        chk("midload_busy", 64'(busy), 64'h1);
        exp_q.push_back({32'h0, tx_words[0]});
        for (int i = 1; i < 4; i++) send_byte(tx_words[0][8*i +: 8], 1'b0);
        exp_q.push_back({32'h4, tx_words[1]});
        send_word(tx_words[1], 1'b0);
        wait_end("midload");
        chk("midload_done", 64'(done), 64'h1);
        chk("midload_pending", 64'(exp_q.size()), 64'h0);

        // start from DONE re-enters the header phase.
        pulse_start();
        chk("restart_done", 64'(done), 64'h0);
        chk("restart_core_rst", 64'(core_rst), 64'h1);
        chk("restart_busy", 64'(busy), 64'h1);
        chk("restart_rx_ready", 64'(rx_ready), 64'h1);
        do_reset();
        check_reset_outputs("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter W, default 32, giving the instruction word and address width.
REQ-002 SHALL have parameter MAX_WORDS, default 2048, giving the largest accepted program length in words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: requests a new program load.
REQ-006 SHALL have port rx_data, input, 8 bits: incoming byte from the serial receiver.
REQ-007 SHALL have port rx_valid, input, 1 bit: rx_data holds a valid byte.
REQ-008 SHALL have port rx_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 SHALL have port is_write, output, 1 bit: write strobe to the instruction RAM.
REQ-010 SHALL have port im_addr, output, W bits: byte address of the RAM write.
REQ-011 SHALL have port im_inst, output, W bits: instruction word to write.
REQ-012 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-013 SHALL have port done, output, 1 bit: the last load completed successfully.
REQ-014 SHALL have port err, output, 1 bit: the last load was rejected.
REQ-015 SHALL have port core_rst, output, 1 bit: holds the CPU core in reset.

Function
REQ-016 SHALL implement states IDLE, HDR, DATA, WRITE, DONE and ERR.
REQ-017 SHALL transfer a byte only in a cycle where rx_valid and rx_ready are both 1.
REQ-018 SHALL drive rx_ready to 1 only in HDR and DATA.
REQ-019 SHALL move from IDLE, DONE or ERR to HDR when start is 1; this clears done, err, the byte counter and the word index.
REQ-020 SHALL ignore start while busy.
REQ-021 In HDR, SHALL assemble 4 bytes little-endian (first byte into bits 7:0) into a word count N.
REQ-022 After the 4th header byte, SHALL enter ERR if N == 0 or N > MAX_WORDS, and SHALL otherwise enter DATA.
REQ-023 In DATA, SHALL assemble 4 bytes little-endian into a word and enter WRITE after the 4th byte.
REQ-024 SHALL hold the WRITE state for exactly 1 cycle.
REQ-025 In WRITE, SHALL drive is_write = 1, im_inst = the assembled word, and im_addr = word index × 4 (word index shifted left by 2).
REQ-026 After WRITE, SHALL increment the word index, then enter DONE if the index equals N and return to DATA otherwise.
REQ-027 SHALL hold is_write at 0 in every state except WRITE.
REQ-028 SHALL hold im_addr and im_inst stable outside WRITE; their values there are don't-care.
REQ-029 SHALL drive busy = 1 exactly in HDR, DATA and WRITE.
REQ-030 SHALL drive done = 1 in DONE and err = 1 in ERR, each held until the next start or rst.
REQ-031 SHALL drive core_rst = 0 only in DONE and 1 in all other states.
REQ-032 SHALL apply no timeout: an incomplete byte stream leaves the block in HDR or DATA indefinitely.
REQ-033 SHALL discard any bytes arriving after DONE or ERR, because rx_ready is 0 in those states.
REQ-034 Assertion of rst during any state SHALL abort the load; words already written remain in the RAM.

Reset
REQ-035 On rst, SHALL enter IDLE and set rx_ready = 0, is_write = 0, im_addr = 0, im_inst = 0, busy = 0, done = 0, err = 0 and core_rst = 1.
REQ-036 SHALL clear the byte counter, word index, N and the assembly register to 0 on rst.

Structure
REQ-037 SHALL take the state enumeration, the 4-bytes-per-word constant and the header length constant from the shared core package.
REQ-038 SHALL contain one sub-module, byte_packer: an 8-to-W little-endian shift-assembler with a byte count and a word-complete pulse, reused for both the header and the data words.
REQ-039 SHALL size the word index and N to hold values up to MAX_WORDS.

Verification
REQ-040 Stream 01 00 00 00, 13 00 00 00 -> one is_write with im_addr = 0x0, im_inst = 0x00000013; then done = 1 and core_rst = 0.
REQ-041 N = 3 with words 0xAABBCCDD, 0x11223344, 0xDEADBEEF -> writes at addresses 0x0, 0x4 and 0x8 with those exact values, then done = 1.
REQ-042 Header 00 00 00 00 -> err = 1, no is_write pulse, core_rst stays 1; then header N = 2049 -> err = 1.
REQ-043 rx_valid toggled randomly during a load of N = 2 -> identical writes; rx_ready = 0 during each WRITE cycle.
REQ-044 rst asserted after 6 data bytes -> IDLE, all outputs at reset values; a fresh start with N = 1 then completes normally.
REQ-045 start pulsed mid-load -> ignored; start in DONE -> done cleared, core_rst = 1, HDR entered.
